// File: rtl/seg_pkg.sv
// Shared constants, scan-state encoding and the active-low hex-to-segment table
// for the multiplexed seven-segment display controller.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [3:0] DIGIT_OFF  = 4'hF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin search: finds the first requester starting just after
// the current holder, or from ptr when there is no holder.
module seg_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic [NUM_REQ-1:0] holder,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    int start_idx;

    always_comb begin
        start_idx = int'(ptr);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (holder[j]) start_idx = (j + 1 == NUM_REQ) ? 0 : j + 1;
        end
    end

    // Nested loop keeps every bit select constant after unrolling.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!valid && req[j] &&
                    j == ((start_idx + k >= NUM_REQ) ? start_idx + k - NUM_REQ : start_idx + k)) begin
                    pick[j] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares a 4-digit active-low multiplexed display between NUM_REQ requesters,
// switching owner only at frame boundaries. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int DWELL_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*16-1:0]   data,
    output logic [NUM_REQ-1:0]      grant,
    output logic [3:0]              digit,
    output logic [7:0]              seg
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    logic [CW-1:0]      cnt_q;
    logic [1:0]         idx_q;
    scan_state_t        state_q, state_d;
    logic [BW-1:0]      blank_q, blank_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [15:0]        snap_q, snap_d;
    logic [3:0]         digit_q, digit_d;
    logic [7:0]         seg_q, seg_d;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic               tick, boundary, lz_off;
    logic [3:0]         nib;

    assign tick     = (cnt_q == CW'(CLK_DIV - 1));
    assign boundary = tick && (idx_q == 2'd3);

    seg_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .holder (grant_q),
        .pick   (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        if (tick) begin
            state_d = ST_BLANK;
            blank_d = '0;
        end else if (state_q == ST_BLANK) begin
            if (blank_q == BW'(BLANK_CYC - 1)) state_d = ST_SHOW;
            else                               blank_d = blank_q + 1'b1;
        end
    end

    // Ownership and the displayed word only move on the 3->0 digit wrap.
    always_comb begin
        grant_d = grant_q;
        dwell_d = dwell_q;
        ptr_d   = ptr_q;
        snap_d  = snap_q;
        if (boundary) begin
            if (|(req & grant_q) && dwell_q < DW'(DWELL_FRAMES - 1)) begin
                dwell_d = dwell_q + 1'b1;
            end else begin
                grant_d = pick_valid ? pick : '0;
                dwell_d = '0;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (grant_d[j]) begin
                    ptr_d  = (j + 1 == NUM_REQ) ? '0 : PW'(j + 1);
                    snap_d = data[16*j +: 16];
                end
            end
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    nib = snap_q[3:0];
            2'd1:    nib = snap_q[7:4];
            2'd2:    nib = snap_q[11:8];
            default: nib = snap_q[15:12];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd0:    lz_off = 1'b0;
            2'd1:    lz_off = (snap_q[15:4] == 12'h000);
            2'd2:    lz_off = (snap_q[15:8] == 8'h00);
            default: lz_off = (snap_q[15:12] == 4'h0);
        endcase
`else
        lz_off = 1'b0;
`endif
        digit_d = DIGIT_OFF;
        seg_d   = SEG_OFF;
        // state_d == SHOW implies no tick, so idx/grant/snap are stable here.
        if (state_d == ST_SHOW && |grant_q && !lz_off) begin
            digit_d = ~(4'b0001 << idx_q);
            seg_d   = hex_to_seg(nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_BLANK;
            blank_q <= '0;
            grant_q <= '0;
            dwell_q <= '0;
            ptr_q   <= '0;
            snap_q  <= '0;
            digit_q <= DIGIT_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            idx_q   <= tick ? idx_q + 2'd1 : idx_q;
            state_q <= state_d;
            blank_q <= blank_d;
            grant_q <= grant_d;
            dwell_q <= dwell_d;
            ptr_q   <= ptr_d;
            snap_q  <= snap_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
        end
    end

    assign grant = grant_q;
    assign digit = digit_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Frame-stepped bench for seg_display_arbiter: table of per-frame req/data with
// expected grants, plus a display scoreboard fed from the granted word.
module tb_seg_display_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NV      = 18;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] data;
    logic [NUM_REQ-1:0]    grant;
    logic [3:0]            digit;
    logic [7:0]            seg;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  exp_grant;
    } vec_t;

    vec_t vecs[NV];

    logic [3:0] req_tab   [NV] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h5, 4'h5, 4'h5,
                                   4'h5, 4'h5, 4'h8, 4'hA, 4'hA, 4'h0, 4'h3, 4'h2, 4'h0};
    logic [3:0] grant_tab [NV] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4,
                                   4'h1, 4'h1, 4'h8, 4'h8, 4'h2, 4'h0, 4'h1, 4'h2, 4'h0};
    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] dig_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    seg_display_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CLK_DIV      (4),
        .BLANK_CYC    (1),
        .DWELL_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .grant (grant),
        .digit (digit),
        .seg   (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] w);
        logic [15:0] hi;
        logic [3:0]  nib;
        logic        skip;
        for (int k = 0; k < 4; k++) begin
            nib  = w[4*k +: 4];
            hi   = w >> (4 * k);
            skip = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && hi == 16'h0000) skip = 1'b1;
`endif
            if (!skip) exp_q.push_back({dig_tab[k], hex_tab[nib]});
        end
    endtask

    function automatic logic [15:0] word_of(input logic [3:0] g, input logic [63:0] d);
        logic [15:0] w;
        w = 16'h0000;
        for (int j = 0; j < NUM_REQ; j++) if (g[j]) w = d[16*j +: 16];
        return w;
    endfunction

    // Display scoreboard: each blank-to-lit transition is one digit slot.
    logic prev_off = 1'b1;
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst) begin
            prev_off = 1'b1;
        end else begin
            if (digit != 4'hF && prev_off) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL show_unexpected: got digit=%h seg=%h, required all off", digit, seg);
                end else begin
                    e = exp_q.pop_front();
                    if ({digit, seg} !== e) begin
                        bad++;
                        $display("FAIL show_slot: got digit=%h seg=%h required digit=%h seg=%h",
                                 digit, seg, e[11:8], e[7:0]);
                    end
                end
            end
            prev_off = (digit == 4'hF);
        end
    end

    initial begin
        logic [3:0] prev_grant;

        for (int i = 0; i < NV; i++) begin
            vecs[i].req       = req_tab[i];
            vecs[i].data      = {$urandom, $urandom};
            vecs[i].exp_grant = grant_tab[i];
        end
        vecs[3].data[15:0]  = 16'h12AB;
        vecs[15].data[15:0] = 16'h0050;
        vecs[16].data[31:16] = 16'h0000;

        rst  = 1'b1;
        req  = '0;
        data = '0;
        repeat (2) @(negedge clk);
        check("reset_digit", {12'h0, digit}, 16'h000F);
        check("reset_seg",   {8'h0, seg},    16'h00FF);
        check("reset_grant", {12'h0, grant}, 16'h0000);
        rst = 1'b0;

        // Inputs change mid-frame; the DUT samples them at the following boundary.
        prev_grant = 4'h0;
        for (int i = 0; i < NV; i++) begin
            repeat (8) @(negedge clk);
            req  = vecs[i].req;
            data = vecs[i].data;
            check($sformatf("grant_mid[%0d]", i), {12'h0, grant}, {12'h0, prev_grant});
            repeat (8) @(negedge clk);
            check($sformatf("grant_bnd[%0d]", i), {12'h0, grant}, {12'h0, vecs[i].exp_grant});
            if (vecs[i].exp_grant != 4'h0) push_frame(word_of(vecs[i].exp_grant, vecs[i].data));
            prev_grant = vecs[i].exp_grant;
        end

        // Asynchronous reset in the middle of a SHOW slot.
        repeat (8) @(negedge clk);
        req  = 4'b0001;
        data = 64'h0;
        data[15:0] = 16'hABCD;
        repeat (8) @(negedge clk);
        check("grant_pre_rst", {12'h0, grant}, 16'h0001);
        push_frame(16'hABCD);
        repeat (2) @(negedge clk);
        check("digit_pre_rst", {12'h0, digit}, 16'h000E);
        #2 rst = 1'b1;
        #1;
        check("async_rst_digit", {12'h0, digit}, 16'h000F);
        check("async_rst_seg",   {8'h0, seg},    16'h00FF);
        check("async_rst_grant", {12'h0, grant}, 16'h0000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        data[15:0] = 16'h0F0F;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("grant_before_bnd", {12'h0, grant}, 16'h0000);
        @(negedge clk);
        check("grant_after_rst_bnd", {12'h0, grant}, 16'h0001);
        push_frame(16'h0F0F);
        repeat (15) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL display_drain: got %0d slots never shown, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
